// File: rtl/signed_mac_drain_requant_pkg.sv
// rtl/signed_mac_drain_requant_pkg.sv - shared widths, modes and limits for the PE drain/requant stage
package signed_mac_drain_requant_pkg;

   localparam int PIXEL_WIDTH_88 = 24;
   localparam int PIXEL_WIDTH_18 = 16;
   localparam int PE_OUT_WIDTH   = 4 * PIXEL_WIDTH_18;
   localparam int BIAS_WIDTH     = 24;
   localparam int SHIFT_WIDTH    = 5;
   localparam int OUT_WIDTH      = 8;
   localparam int INT_WIDTH      = 34;

   localparam logic MODE_88 = 1'b0;
   localparam logic MODE_18 = 1'b1;

   localparam int LANES_88 = 2;
   localparam int LANES_18 = 4;
   localparam logic [1:0] LAST_LANE_88 = 2'(LANES_88 - 1);
   localparam logic [1:0] LAST_LANE_18 = 2'(LANES_18 - 1);

   localparam logic signed [INT_WIDTH-1:0] OUT_MIN = INT_WIDTH'(-128);
   localparam logic signed [INT_WIDTH-1:0] OUT_MAX = INT_WIDTH'(127);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

   function automatic logic [1:0] last_lane(input logic mode);
      return (mode == MODE_18) ? LAST_LANE_18 : LAST_LANE_88;
   endfunction

endpackage

// File: rtl/signed_mac_drain_requant_requant_lane.sv
// rtl/signed_mac_drain_requant_requant_lane.sv - one lane: sign-extend, add bias, round half-up, shift, saturate to int8
module requant_lane
   import signed_mac_drain_requant_pkg::*;
(
   input  logic [PIXEL_WIDTH_88-1:0] lane_i,
   input  logic [BIAS_WIDTH-1:0]     bias_i,
   input  logic [SHIFT_WIDTH-1:0]    shift_i,
   output logic [OUT_WIDTH-1:0]      data_o
);

   logic signed [INT_WIDTH-1:0] lane_x;
   logic signed [INT_WIDTH-1:0] bias_x;
   logic signed [INT_WIDTH-1:0] sum;
   logic signed [INT_WIDTH-1:0] rnd;
   logic signed [INT_WIDTH-1:0] q;

   // 34 bits holds 24b+24b plus the 2^30 rounding term without overflow
   always_comb begin
      lane_x = {{(INT_WIDTH-PIXEL_WIDTH_88){lane_i[PIXEL_WIDTH_88-1]}}, lane_i};
      bias_x = {{(INT_WIDTH-BIAS_WIDTH){bias_i[BIAS_WIDTH-1]}}, bias_i};
      sum    = lane_x + bias_x;
      rnd    = '0;
      if (shift_i != '0)
         rnd = INT_WIDTH'(1) << (shift_i - SHIFT_WIDTH'(1));
      q = (sum + rnd) >>> shift_i;
      if (q > OUT_MAX)
         data_o = OUT_MAX[OUT_WIDTH-1:0];
      else if (q < OUT_MIN)
         data_o = OUT_MIN[OUT_WIDTH-1:0];
      else
         data_o = q[OUT_WIDTH-1:0];
   end

endmodule

// File: rtl/signed_mac_drain_requant.sv
// rtl/signed_mac_drain_requant.sv - snapshots the packed PE accumulator and drains requantised lanes one per cycle
module signed_mac_drain_requant
   import signed_mac_drain_requant_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      mode,
   input  logic                      psum_valid,
   output logic                      psum_ready,
   input  logic [PE_OUT_WIDTH-1:0]   psum_in,
   input  logic [BIAS_WIDTH-1:0]     bias_in,
   input  logic [SHIFT_WIDTH-1:0]    shift_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OUT_WIDTH-1:0]      out_data,
   output logic [1:0]                out_lane,
   output logic                      out_last
);

   state_e                    state_q;
   logic [PE_OUT_WIDTH-1:0]   psum_q;
   logic                      mode_q;
   logic [BIAS_WIDTH-1:0]     bias_q;
   logic [SHIFT_WIDTH-1:0]    shift_q;
   logic [1:0]                lane_q;
   logic [1:0]                lane_d;
   logic                      lane_is_last;
   logic [PIXEL_WIDTH_18-1:0] lane18;
   logic [PIXEL_WIDTH_88-1:0] lane_sel;
   logic [OUT_WIDTH-1:0]      rq_data;

   assign lane_d       = lane_q + 2'd1;
   assign lane_is_last = (lane_q == last_lane(mode_q));

   // Mode-1 lanes are widened to 24b here so a single requant datapath serves both modes
   always_comb begin
      lane18   = psum_q[{lane_q, 4'b0000} +: PIXEL_WIDTH_18];
      lane_sel = '0;
      if (mode_q == MODE_18)
         lane_sel = {{(PIXEL_WIDTH_88-PIXEL_WIDTH_18){lane18[PIXEL_WIDTH_18-1]}}, lane18};
      else if (lane_q[0])
         lane_sel = psum_q[2*PIXEL_WIDTH_88-1:PIXEL_WIDTH_88];
      else
         lane_sel = psum_q[PIXEL_WIDTH_88-1:0];
   end

   requant_lane u_requant_lane (
      .lane_i  (lane_sel),
      .bias_i  (bias_q),
      .shift_i (shift_q),
      .data_o  (rq_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         psum_q  <= '0;
         mode_q  <= MODE_88;
         bias_q  <= '0;
         shift_q <= '0;
         lane_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (psum_valid) begin
                  psum_q  <= psum_in;
                  mode_q  <= mode;
                  bias_q  <= bias_in;
                  shift_q <= shift_in;
                  lane_q  <= '0;
                  state_q <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (out_ready) begin
                  if (lane_is_last) begin
                     lane_q  <= '0;
                     state_q <= ST_IDLE;
                  end else begin
                     lane_q  <= lane_d;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign psum_ready = (state_q == ST_IDLE);
   assign out_valid  = (state_q == ST_EMIT);
   assign out_lane   = lane_q;
   assign out_last   = out_valid & lane_is_last;
   assign out_data   = out_valid ? rq_data : '0;

endmodule

// File: tb/tb_signed_mac_drain_requant.sv
// tb/tb_signed_mac_drain_requant.sv - directed bench with expected-lane scoreboard and output monitor
module tb_signed_mac_drain_requant;

   logic        clk = 1'b0;
   logic        reset;
   logic        mode;
   logic        psum_valid;
   logic        psum_ready;
   logic [63:0] psum_in;
   logic [23:0] bias_in;
   logic [4:0]  shift_in;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_lane;
   logic        out_last;

   typedef struct {
      logic [7:0] data;
      logic [1:0] lane;
      logic       last;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   logic chk_idle = 1'b0;

   always #5 clk = ~clk;

   signed_mac_drain_requant dut (
      .clk        (clk),
      .reset      (reset),
      .mode       (mode),
      .psum_valid (psum_valid),
      .psum_ready (psum_ready),
      .psum_in    (psum_in),
      .bias_in    (bias_in),
      .shift_in   (shift_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_lane   (out_lane),
      .out_last   (out_last)
   );

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic [1:0] l, input logic last);
      exp_t e;
      e.data = d;
      e.lane = l;
      e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic capture(input logic m, input logic [63:0] p, input logic [23:0] b,
                          input logic [4:0] s);
      int n = 0;
      @(negedge clk);
      while (!psum_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("capture_ready", int'(psum_ready), 1);
      mode       = m;
      psum_in    = p;
      bias_in    = b;
      shift_in   = s;
      psum_valid = 1'b1;
      @(posedge clk);
      #1 psum_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted beat must match the head of the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (chk_idle) begin
            chk_idle = 1'b0;
            check("idle_psum_ready", int'(psum_ready), 1);
            check("idle_out_valid", int'(out_valid), 0);
         end
         if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_output: got data 0x%0h lane %0d, expected nothing", out_data, out_lane);
            end else begin
               e = exp_q.pop_front();
               check("out_data", int'(out_data), int'(e.data));
               check("out_lane", int'(out_lane), int'(e.lane));
               check("out_last", int'(out_last), int'(e.last));
               if (e.last) chk_idle = 1'b1;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      reset      = 1'b1;
      mode       = 1'b0;
      psum_valid = 1'b0;
      psum_in    = '0;
      bias_in    = '0;
      shift_in   = '0;
      out_ready  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_psum_ready", int'(psum_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_lane", int'(out_lane), 0);
      check("rst_out_last", int'(out_last), 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // mode 0 basic, upper 16 bits are junk and must be ignored
      push(8'd100, 2'd0, 1'b0);
      push(8'h9C,  2'd1, 1'b1);
      capture(1'b0, {16'hABCD, 24'hFFFF9C, 24'd100}, 24'd0, 5'd0);
      drain();

      // mode 1 with saturation: 300, -300, 5, -6
      push(8'h7F, 2'd0, 1'b0);
      push(8'h80, 2'd1, 1'b0);
      push(8'h05, 2'd2, 1'b0);
      push(8'hFA, 2'd3, 1'b1);
      capture(1'b1, {16'hFFFA, 16'h0005, 16'hFED4, 16'h012C}, 24'd0, 5'd0);
      drain();

      // rounding: 5, -5 with shift 1 -> 3, -2
      push(8'h03, 2'd0, 1'b0);
      push(8'hFE, 2'd1, 1'b1);
      capture(1'b0, {16'h0000, 24'hFFFFFB, 24'd5}, 24'd0, 5'd1);
      drain();

      // mode 1, bias 30, shift 2: -20 -> 3, zeros -> 8
      push(8'h03, 2'd0, 1'b0);
      push(8'h08, 2'd1, 1'b0);
      push(8'h08, 2'd2, 1'b0);
      push(8'h08, 2'd3, 1'b1);
      capture(1'b1, {16'h0000, 16'h0000, 16'h0000, 16'hFFEC}, 24'd30, 5'd2);
      drain();

      // mode 0 saturation at both ends of the 24-bit range
      push(8'h7F, 2'd0, 1'b0);
      push(8'h80, 2'd1, 1'b1);
      capture(1'b0, {16'h0000, 24'h800000, 24'h7FFFFF}, 24'd0, 5'd0);
      drain();

      // backpressure on lane 0 while upstream presents a different word
      @(posedge clk);
      #1 out_ready = 1'b0;
      push(8'd1, 2'd0, 1'b0);
      push(8'd2, 2'd1, 1'b0);
      push(8'd3, 2'd2, 1'b0);
      push(8'd4, 2'd3, 1'b1);
      capture(1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, 24'd0, 5'd0);
      mode       = 1'b0;
      psum_in    = 64'h1111_2222_3333_4444;
      psum_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_out_data", int'(out_data), 1);
         check("bp_out_lane", int'(out_lane), 0);
         check("bp_psum_ready", int'(psum_ready), 0);
      end
      @(posedge clk);
      #1;
      psum_valid = 1'b0;
      out_ready  = 1'b1;
      drain();

      // reset after lane 1 of a mode 1 snapshot
      push(8'd10, 2'd0, 1'b0);
      push(8'd20, 2'd1, 1'b0);
      capture(1'b1, {16'd40, 16'd30, 16'd20, 16'd10}, 24'd0, 5'd0);
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      check("mid_drain_empty", exp_q.size(), 0);
      #1;
      reset     = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("mid_rst_out_valid", int'(out_valid), 0);
      check("mid_rst_psum_ready", int'(psum_ready), 1);
      check("mid_rst_out_lane", int'(out_lane), 0);
      push(8'd7, 2'd0, 1'b0);
      push(8'd8, 2'd1, 1'b1);
      capture(1'b0, {16'h0000, 24'd8, 24'd7}, 24'd0, 5'd0);
      drain();

      // extreme bias with maximum shift
      push(8'd0, 2'd0, 1'b0);
      push(8'd0, 2'd1, 1'b1);
      capture(1'b0, {16'h0000, 24'h7FFFFF, 24'h7FFFFF}, 24'h7FFFFF, 5'd31);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/signed_mac_drain_requant.md
Name: signed_mac_drain_requant

Overview:
- Downstream stage of the packed-DSP signed MAC PE.
- Takes a snapshot of the PE's packed accumulator word once accumulation is complete.
  - mode 0: two 24-bit sums.
  - mode 1: four 16-bit sums.
- Unpacks and sign-extends each lane, adds bias, rounds, shifts and saturates to int8.
- Emits one lane per cycle on a valid/ready stream to the output buffer. Frees the PE for its next reset/accumulate pass right after capture.

Parameters:
- PIXEL_WIDTH_88, 24, lane width in mode 0.
- PIXEL_WIDTH_18, 16, lane width in mode 1.
- PE_OUT_WIDTH, 64, packed accumulator width (4*PIXEL_WIDTH_18).
- BIAS_WIDTH, 24, signed bias width.
- SHIFT_WIDTH, 5, requant right-shift amount width.
- OUT_WIDTH, 8, signed output width.
- INT_WIDTH, 34, internal arithmetic width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- mode  in  1  0 = 8x8 (2 lanes of 24b), 1 = 1x8 (4 lanes of 16b); sampled on capture.
- psum_valid  in  1  packed accumulator word is final.
- psum_ready  out  1  block can capture.
- psum_in  in  PE_OUT_WIDTH  packed PE accumulator word.
- bias_in  in  BIAS_WIDTH  signed bias, added to every lane; sampled on capture.
- shift_in  in  SHIFT_WIDTH  arithmetic right-shift amount; sampled on capture.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts.
- out_data  out  OUT_WIDTH  saturated signed result.
- out_lane  out  2  lane index of out_data.
- out_last  out  1  high with the final lane of a snapshot.

Behaviour:
- Reset values: state IDLE; psum_ready=1; out_valid=0, out_data=0, out_lane=0, out_last=0; snapshot registers cleared.
- States: IDLE and EMIT.
  - IDLE: psum_ready=1. On psum_valid=1, register psum_in, mode, bias_in and shift_in; set lane_idx=0; go to EMIT.
  - EMIT: psum_ready=0 and out_valid=1. On out_valid&out_ready:
    - if lane_idx==last (1 in mode 0, 3 in mode 1), go to IDLE;
    - otherwise lane_idx++.
- Latency:
  - Capture at edge N; lane 0 valid in the cycle after N.
  - With out_ready held high, throughput is one lane per cycle: 2 cycles per snapshot in mode 0, 4 in mode 1.
  - psum_ready returns in the cycle after the last accept. There are no back-to-back captures without one IDLE cycle.
- out_data, out_lane and out_last come directly from registers plus lane-mux logic on registered values. They are held stable while out_valid=1 and out_ready=0.
- psum_valid in EMIT is ignored and the snapshot is not overwritten. The upstream controller holds psum_valid until it sees psum_ready.
- Lane extraction:
  - mode 0: lane i = psum[24i +: 24], i in 0..1. Bits 63:48 are ignored.
  - mode 1: lane i = psum[16i +: 16], i in 0..3.
  - Each lane is sign-extended to INT_WIDTH.
- Arithmetic, all in INT_WIDTH signed:
  - sum = lane + sext(bias).
  - rnd = (shift==0) ? 0 : 1<<(shift-1).
  - q = (sum+rnd) >>> shift. This is round-half-up toward +inf.
  - out = clamp(q, -128, 127).
- shift range is 0..31. Saturation applies to every lane, including mode 0.
- A reset in any state, including mid-EMIT, discards the snapshot and returns to reset values on the next edge. Partial emission is not resumed.
- There are no further boundary states. The two-state FSM with lane_idx covers empty/full; the buffering is single-entry.

Decomposition:
- Shared package: lane widths, PE_OUT_WIDTH, mode encodings (MODE_88=0, MODE_18=1), lanes-per-mode constants, OUT_MIN=-128 and OUT_MAX=127.
- One sub-module is natural: requant_lane. It is combinational and does sign-extend + bias + round + shift + saturate for a single lane. It is instantiated once, after the lane mux.

Test Plan:
- mode0, psum lane0=100 and lane1=-100 (0xFFFF9C), bias 0, shift 0, out_ready=1 -> outputs 100 (lane 0) then 0x9C (lane 1, out_last=1); psum_ready=1 on the following cycle.
- mode1, lanes 300, -300, 5, -6, bias 0, shift 0 -> outputs 127, -128, 5, -6 on lanes 0..3 in consecutive cycles; out_last only with lane 3.
- Rounding, mode0: lane0=5, lane1=-5, shift 1 -> 3, then -2. Then mode1 lane0=-20, bias 30, shift 2 -> 3.
- Backpressure: out_ready=0 for 3 cycles on lane 0, with psum_valid=1 and a different psum_in -> out_data/out_lane held, psum_ready=0, snapshot unchanged; after release, the original values drain.
- Reset after lane 1 of a mode1 snapshot -> next cycle out_valid=0, psum_ready=1. A new capture (mode0, 7, 8) emits 7 on lane 0, then 8 on lane 1 with out_last.
- Extreme bias: mode0, lane=0x7FFFFF, bias 0x7FFFFF, shift 31 -> no internal overflow; output 0.
